// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline types and widths.
package legv8_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register; a bubble clears control bits and keeps the data fields.
module mem_wb
  import legv8_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bubble,
  input  wb_ctrl_t              ctrl_in,
  input  logic [XLEN-1:0]       read_data_in,
  input  logic [XLEN-1:0]       alu_result_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  output wb_ctrl_t              ctrl_out,
  output logic [XLEN-1:0]       read_data_out,
  output logic [XLEN-1:0]       alu_result_out,
  output logic [REG_ADDR_W-1:0] write_reg_out
);

  // Pipeline register update: reset, bubble, or load.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_out       <= '0;
      read_data_out  <= '0;
      alu_result_out <= '0;
      write_reg_out  <= '0;
    end else if (bubble) begin
      ctrl_out <= '0;
    end else begin
      ctrl_out       <= ctrl_in;
      read_data_out  <= read_data_in;
      alu_result_out <= alu_result_in;
      write_reg_out  <= write_reg_in;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// LEGv8 MEM stage: data-memory handshake, pipeline stall, branch resolve, MEM/WB register.
module mem_stage
  import legv8_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [XLEN-1:0]       Add_result,
  input  logic [XLEN-1:0]       Alu_result,
  input  logic                  Zero,
  input  logic [XLEN-1:0]       Read2,
  input  logic [REG_ADDR_W-1:0] Write_reg,
  input  logic                  Branch,
  input  logic                  UncBranch,
  input  logic                  Memread,
  input  logic                  Memwrite,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  mem_stall,
  output logic                  pc_src,
  output logic [XLEN-1:0]       branch_target,
  output logic                  mem_error,
  output logic [XLEN-1:0]       wb_read_data,
  output logic [XLEN-1:0]       wb_alu_result,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state;
  mem_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rdata_q;
  logic [XLEN-1:0]  cap_data;
  logic [XLEN-1:0]  retire_data;
  logic             mem_op;
  logic             is_load;
  logic             stall;
  logic             cap_en;
  logic             timeout_set;
  wb_ctrl_t         ctrl_in;
  wb_ctrl_t         ctrl_out;

  // A store wins when both read and write are requested.
  assign mem_op  = Memread | Memwrite;
  assign is_load = Memread & ~Memwrite;

  assign dmem_we       = Memwrite;
  assign dmem_addr     = Alu_result;
  assign dmem_wdata    = Read2;
  assign branch_target = Add_result;
  assign mem_stall     = stall;
  assign pc_src        = ((Branch & Zero) | UncBranch) & ~stall;

  // Next-state, stall and capture decode.
  always_comb begin
    state_next  = state;
    stall       = 1'b0;
    cap_en      = 1'b0;
    cap_data    = '0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_ack) begin
          cap_en     = 1'b1;
          cap_data   = is_load ? dmem_rdata : '0;
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          cap_en      = 1'b1;
          timeout_set = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request line, timeout counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      dmem_req  <= 1'b0;
      cnt       <= '0;
      mem_error <= 1'b0;
    end else begin
      dmem_req <= (state_next == REQ);
      cnt      <= (state == REQ) ? cnt + CNT_W'(1) : '0;
      if (timeout_set) begin
        mem_error <= 1'b1;
      end
    end
  end

  // Holds load data (or 0 on abort/store) until the DONE retire edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (cap_en) begin
      rdata_q <= cap_data;
    end
  end

  assign retire_data      = (state == DONE) ? rdata_q : '0;
  assign ctrl_in.regwrite = RegWrite;
  assign ctrl_in.memtoreg = MemtoReg;

  mem_wb u_mem_wb (
    .clock          (clock),
    .reset          (reset),
    .bubble         (stall),
    .ctrl_in        (ctrl_in),
    .read_data_in   (retire_data),
    .alu_result_in  (Alu_result),
    .write_reg_in   (Write_reg),
    .ctrl_out       (ctrl_out),
    .read_data_out  (wb_read_data),
    .alu_result_out (wb_alu_result),
    .write_reg_out  (wb_write_reg)
  );

  assign wb_regwrite = ctrl_out.regwrite;
  assign wb_memtoreg = ctrl_out.memtoreg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] Add_result, Alu_result, Read2;
  logic        Zero;
  logic [4:0]  Write_reg;
  logic        Branch, UncBranch, Memread, Memwrite, RegWrite, MemtoReg;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, pc_src, mem_error;
  logic [63:0] branch_target, wb_read_data, wb_alu_result;
  logic [4:0]  wb_write_reg;
  logic        wb_regwrite, wb_memtoreg;

  typedef struct {
    logic [63:0] add, alu, rd2;
    logic        zero;
    logic [4:0]  wr;
    logic        br, ubr, mr, mw, rw, m2r;
  } op_t;

  int          checks = 0;
  int          fails = 0;
  logic [63:0] m_alu, m_rdata;
  logic        m_rdata_known, m_err;
  int          ns, nr;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .Add_result(Add_result), .Alu_result(Alu_result),
    .Zero(Zero), .Read2(Read2), .Write_reg(Write_reg), .Branch(Branch),
    .UncBranch(UncBranch), .Memread(Memread), .Memwrite(Memwrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .pc_src(pc_src), .branch_target(branch_target),
    .mem_error(mem_error), .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
    .wb_write_reg(wb_write_reg), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic op_t nop();
    op_t o;
    o.add = '0; o.alu = '0; o.rd2 = '0; o.zero = 1'b0; o.wr = '0;
    o.br = 1'b0; o.ubr = 1'b0; o.mr = 1'b0; o.mw = 1'b0; o.rw = 1'b0; o.m2r = 1'b0;
    return o;
  endfunction

  // Model: REQ cycles spent; d is the REQ cycle carrying ack (0 or >T = never acked).
  function automatic int exp_req(op_t o, int d);
    if (!(o.mr || o.mw)) return 0;
    return (d >= 1 && d <= T) ? d : T;
  endfunction

  function automatic int exp_stall(op_t o, int d);
    return (o.mr || o.mw) ? exp_req(o, d) + 1 : 0;
  endfunction

  function automatic logic [63:0] exp_rdata(op_t o, int d, logic [63:0] rd);
    return (o.mr && !o.mw && d >= 1 && d <= T) ? rd : 64'd0;
  endfunction

  task automatic drive(input op_t o);
    Add_result = o.add; Alu_result = o.alu; Read2 = o.rd2; Zero = o.zero;
    Write_reg = o.wr; Branch = o.br; UncBranch = o.ubr; Memread = o.mr;
    Memwrite = o.mw; RegWrite = o.rw; MemtoReg = o.m2r;
  endtask

  task automatic do_reset();
    @(negedge clock);
    drive(nop());
    dmem_ack = 1'b0; dmem_rdata = '0; reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_alu = '0; m_rdata = '0; m_rdata_known = 1'b1; m_err = 1'b0;
  endtask

  // Presents one instruction at a negedge and runs it until it retires.
  task automatic run_op(input op_t o, input int d, input logic [63:0] rd,
                        output int n_stall, output int n_req);
    bit   done;
    logic stalled, exp_pc;
    drive(o);
    dmem_rdata = rd; dmem_ack = 1'b0;
    n_stall = 0; n_req = 0; done = 0;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      stalled = mem_stall;
      exp_pc  = !stalled && ((o.br && o.zero) || o.ubr);
      checks++;
      if (pc_src !== exp_pc || branch_target !== o.add) begin
        fails++;
        $display("FAIL branch_out cyc %0d: pc_src=%b target=%h, expected %b %h",
                 c, pc_src, branch_target, exp_pc, o.add);
      end
      if (dmem_req === 1'b1) begin
        n_req++;
        checks++;
        if (dmem_addr !== o.alu || dmem_wdata !== o.rd2 || dmem_we !== o.mw) begin
          fails++;
          $display("FAIL req_hold: addr=%h wdata=%h we=%b, expected %h %h %b",
                   dmem_addr, dmem_wdata, dmem_we, o.alu, o.rd2, o.mw);
        end
        dmem_ack = (n_req == d);
      end
      if (stalled === 1'b1) n_stall++;
      @(posedge clock);
      @(negedge clock);
      dmem_ack = 1'b0;
      if (stalled === 1'b1) begin
        checks++;
        if (wb_regwrite !== 1'b0 || wb_memtoreg !== 1'b0 || wb_alu_result !== m_alu ||
            (m_rdata_known && wb_read_data !== m_rdata)) begin
          fails++;
          $display("FAIL bubble: rw=%b m2r=%b alu=%h rdata=%h, expected 0 0 %h %h",
                   wb_regwrite, wb_memtoreg, wb_alu_result, wb_read_data, m_alu, m_rdata);
        end
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL retire_bound: instruction did not retire within 40 cycles");
    end
    m_alu = o.alu;
    m_rdata_known = o.mr || o.mw;
    m_rdata = exp_rdata(o, d, rd);
    if ((o.mr || o.mw) && !(d >= 1 && d <= T)) m_err = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; drive(nop()); dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (dmem_req !== 1'b0 || mem_error !== 1'b0 || mem_stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: req=%b err=%b stall=%b, expected 0 0 0", dmem_req, mem_error, mem_stall);
    end
    checks++;
    if (wb_read_data !== '0 || wb_alu_result !== '0 || wb_write_reg !== '0 ||
        wb_regwrite !== 1'b0 || wb_memtoreg !== 1'b0) begin
      fails++;
      $display("FAIL reset_wb: rdata=%h alu=%h wr=%0d rw=%b m2r=%b, expected all 0",
               wb_read_data, wb_alu_result, wb_write_reg, wb_regwrite, wb_memtoreg);
    end
    reset = 1'b0;
    m_alu = '0; m_rdata = '0; m_rdata_known = 1'b1; m_err = 1'b0;
  endtask

  task automatic test_alu();
    op_t o = nop();
    o.alu = 64'h2A; o.wr = 5'd5; o.rw = 1'b1;
    run_op(o, 0, '0, ns, nr);
    checks++;
    if (ns !== 0 || wb_alu_result !== 64'h2A || wb_write_reg !== 5'd5 ||
        wb_regwrite !== 1'b1 || wb_memtoreg !== 1'b0) begin
      fails++;
      $display("FAIL alu_retire: stalls=%0d alu=%h wr=%0d rw=%b m2r=%b, expected 0 2a 5 1 0",
               ns, wb_alu_result, wb_write_reg, wb_regwrite, wb_memtoreg);
    end
  endtask

  task automatic test_load();
    op_t o = nop();
    o.alu = 64'h100; o.wr = 5'd9; o.mr = 1'b1; o.rw = 1'b1; o.m2r = 1'b1;
    run_op(o, 3, 64'hDEADBEEF, ns, nr);
    checks++;
    if (ns !== 4 || nr !== 3) begin
      fails++;
      $display("FAIL load_timing: stalls=%0d reqs=%0d, expected 4 3", ns, nr);
    end
    checks++;
    if (wb_read_data !== 64'hDEADBEEF || wb_memtoreg !== 1'b1 || wb_regwrite !== 1'b1 ||
        wb_write_reg !== 5'd9 || mem_error !== 1'b0) begin
      fails++;
      $display("FAIL load_retire: rdata=%h m2r=%b rw=%b wr=%0d err=%b, expected deadbeef 1 1 9 0",
               wb_read_data, wb_memtoreg, wb_regwrite, wb_write_reg, mem_error);
    end
  endtask

  task automatic test_store();
    op_t o = nop();
    o.alu = 64'h80; o.rd2 = 64'h55; o.mw = 1'b1;
    run_op(o, 1, 64'h9999, ns, nr);
    checks++;
    if (ns !== 2 || nr !== 1 || wb_regwrite !== 1'b0) begin
      fails++;
      $display("FAIL store_retire: stalls=%0d reqs=%0d rw=%b, expected 2 1 0", ns, nr, wb_regwrite);
    end
    o.mr = 1'b1; o.rd2 = 64'hABCD;
    run_op(o, 2, 64'h1234, ns, nr);
    checks++;
    if (ns !== 3 || wb_read_data !== 64'd0) begin
      fails++;
      $display("FAIL rw_both: stalls=%0d rdata=%h, expected 3 0", ns, wb_read_data);
    end
  endtask

  task automatic test_branch();
    op_t o = nop();
    o.br = 1'b1; o.zero = 1'b1; o.add = 64'h400;
    drive(o); #1;
    checks++;
    if (pc_src !== 1'b1 || branch_target !== 64'h400) begin
      fails++;
      $display("FAIL cbz_taken: pc_src=%b target=%h, expected 1 400", pc_src, branch_target);
    end
    o.zero = 1'b0; drive(o); #1;
    checks++;
    if (pc_src !== 1'b0) begin
      fails++;
      $display("FAIL cbz_not_taken: pc_src=%b, expected 0", pc_src);
    end
    o.br = 1'b0; o.ubr = 1'b1; drive(o); #1;
    checks++;
    if (pc_src !== 1'b1) begin
      fails++;
      $display("FAIL uncbranch: pc_src=%b, expected 1", pc_src);
    end
    run_op(o, 0, '0, ns, nr);
    o = nop(); o.br = 1'b1; o.zero = 1'b1; o.add = 64'h800; o.mr = 1'b1; o.alu = 64'h40;
    run_op(o, 2, 64'h77, ns, nr);
  endtask

  task automatic test_timeout();
    op_t o = nop();
    do_reset();
    o.alu = 64'h200; o.mr = 1'b1; o.rw = 1'b1; o.m2r = 1'b1; o.wr = 5'd3;
    run_op(o, 0, 64'hFFFF, ns, nr);
    checks++;
    if (nr !== 4 || ns !== 5 || mem_error !== 1'b1 || wb_read_data !== 64'd0) begin
      fails++;
      $display("FAIL timeout: reqs=%0d stalls=%0d err=%b rdata=%h, expected 4 5 1 0",
               nr, ns, mem_error, wb_read_data);
    end
    o = nop(); o.alu = 64'h11; o.rw = 1'b1;
    run_op(o, 0, '0, ns, nr);
    checks++;
    if (mem_error !== 1'b1) begin
      fails++;
      $display("FAIL error_sticky: err=%b, expected 1", mem_error);
    end
  endtask

  task automatic test_ack_at_timeout();
    op_t o = nop();
    do_reset();
    o.alu = 64'h300; o.mr = 1'b1; o.rw = 1'b1;
    run_op(o, T, 64'hCAFE, ns, nr);
    checks++;
    if (nr !== T || mem_error !== 1'b0 || wb_read_data !== 64'hCAFE) begin
      fails++;
      $display("FAIL ack_wins: reqs=%0d err=%b rdata=%h, expected 4 0 cafe", nr, mem_error, wb_read_data);
    end
  endtask

  task automatic test_reset_during_req();
    op_t o = nop();
    int  seen = 0;
    o.alu = 64'h500; o.mr = 1'b1; o.rw = 1'b1; o.wr = 5'd7;
    drive(o); dmem_ack = 1'b0;
    for (int c = 0; c < 10 && seen < 2; c++) begin
      @(posedge clock); @(negedge clock);
      if (dmem_req === 1'b1) seen++;
    end
    checks++;
    if (seen !== 2) begin
      fails++;
      $display("FAIL req_start: saw %0d request cycles, expected 2", seen);
    end
    reset = 1'b1; drive(nop());
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_regwrite !== 1'b0 || wb_memtoreg !== 1'b0 ||
        wb_alu_result !== '0 || wb_read_data !== '0 || wb_write_reg !== '0 || mem_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_req: req=%b stall=%b rw=%b alu=%h rdata=%h wr=%0d err=%b, expected all 0",
               dmem_req, mem_stall, wb_regwrite, wb_alu_result, wb_read_data, wb_write_reg, mem_error);
    end
    m_alu = '0; m_rdata = '0; m_rdata_known = 1'b1; m_err = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 64'hBAD;
    @(posedge clock); @(negedge clock);
    dmem_ack = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_read_data !== '0) begin
      fails++;
      $display("FAIL late_ack: req=%b stall=%b rdata=%h, expected 0 0 0", dmem_req, mem_stall, wb_read_data);
    end
    o = nop(); o.alu = 64'h66; o.rw = 1'b1; o.wr = 5'd2;
    run_op(o, 0, '0, ns, nr);
    checks++;
    if (ns !== 0 || wb_alu_result !== 64'h66 || wb_regwrite !== 1'b1) begin
      fails++;
      $display("FAIL after_reset_op: stalls=%0d alu=%h rw=%b, expected 0 66 1", ns, wb_alu_result, wb_regwrite);
    end
  endtask

  task automatic test_random();
    op_t         o;
    int          d, sel;
    logic [63:0] rd;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      o.add = {$urandom, $urandom}; o.alu = {$urandom, $urandom}; o.rd2 = {$urandom, $urandom};
      o.zero = 1'($urandom); o.wr = 5'($urandom); o.br = 1'($urandom); o.ubr = 1'($urandom_range(0, 3) == 0);
      o.rw = 1'($urandom); o.m2r = 1'($urandom);
      sel = $urandom_range(0, 3);
      o.mr = (sel == 1 || sel == 3); o.mw = (sel == 2 || sel == 3);
      d = $urandom_range(1, 6);
      rd = {$urandom, $urandom};
      run_op(o, d, rd, ns, nr);
      checks++;
      if (ns !== exp_stall(o, d) || nr !== exp_req(o, d)) begin
        fails++;
        $display("FAIL rand_timing #%0d: stalls=%0d reqs=%0d, expected %0d %0d",
                 i, ns, nr, exp_stall(o, d), exp_req(o, d));
      end
      checks++;
      if (wb_alu_result !== o.alu || wb_write_reg !== o.wr || wb_regwrite !== o.rw ||
          wb_memtoreg !== o.m2r || mem_error !== m_err) begin
        fails++;
        $display("FAIL rand_retire #%0d: alu=%h wr=%0d rw=%b m2r=%b err=%b, expected %h %0d %b %b %b",
                 i, wb_alu_result, wb_write_reg, wb_regwrite, wb_memtoreg, mem_error,
                 o.alu, o.wr, o.rw, o.m2r, m_err);
      end
      if (o.mr || o.mw) begin
        checks++;
        if (wb_read_data !== exp_rdata(o, d, rd)) begin
          fails++;
          $display("FAIL rand_rdata #%0d: rdata=%h, expected %h", i, wb_read_data, exp_rdata(o, d, rd));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_timeout();
    test_ack_at_timeout();
    test_reset_during_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

MEM stage of the LEGv8 pipelined CPU, sitting between the EX/MEM pipeline register and the WB stage. It issues loads and stores to an external multi-cycle data memory through a request/acknowledge handshake and holds the upstream pipeline while an access is in flight. It also resolves branches, producing `pc_src` and the branch target. The MEM/WB pipeline register is built into this block.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in REQ before the access is aborted.
- `clock`  in  1  single clock, all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `Add_result`  in  64  branch target from EX/MEM.
- `Alu_result`  in  64  memory address, or ALU value for write-back.
- `Zero`  in  1  ALU zero flag.
- `Read2`  in  64  store data.
- `Write_reg`  in  5  destination register.
- `Branch`, `UncBranch`, `Memread`, `Memwrite`, `RegWrite`, `MemtoReg`  in  1 each  control bits from EX/MEM.
- `dmem_req`  out  1  access request; registered.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  64  equals `Alu_result`.
- `dmem_wdata`  out  64  equals `Read2`.
- `dmem_ack`  in  1  access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  64  load data.
- `mem_stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- `pc_src`  out  1  taken-branch select to the IF stage.
- `branch_target`  out  64  equals `Add_result`.
- `mem_error`  out  1  sticky timeout flag; cleared only by reset.
- `wb_read_data`  out  64  MEM/WB load data.
- `wb_alu_result`  out  64  MEM/WB ALU value.
- `wb_write_reg`  out  5  MEM/WB destination register.
- `wb_regwrite`, `wb_memtoreg`  out  1 each  MEM/WB control bits.

## Operation
- Memory op: `Memread | Memwrite`. If both are set, the access is a store (`dmem_we`=1) and `wb_read_data` retires as 0.
- FSM states: IDLE, REQ, DONE.
  - IDLE, memory op present: `mem_stall`=1; next state REQ; `dmem_req` is set for the next cycle.
  - IDLE, no memory op: `mem_stall`=0; the instruction retires into MEM/WB at the edge; state stays IDLE.
  - REQ: `dmem_req`=1, `mem_stall`=1, timeout counter increments each cycle.
    - On `dmem_ack`: capture `dmem_rdata`, clear `dmem_req`, go to DONE.
    - Counter reaches `TIMEOUT_CYCLES-1` without ack: set `mem_error`, capture 0, clear `dmem_req`, go to DONE.
    - Ack and timeout in the same cycle: ack wins and `mem_error` is not set.
  - DONE: `mem_stall`=0; the instruction retires into MEM/WB with the captured data at the edge; next state IDLE; counter cleared.
- `dmem_ack` outside REQ is ignored.
- MEM/WB update rules:
  - Every edge with `mem_stall`=1 loads a bubble: `wb_regwrite`=0, `wb_memtoreg`=0, data fields unchanged.
  - Non-stall edges load the EX/MEM fields.
- `pc_src` = `(Branch & Zero) | UncBranch`, combinational. It is forced to 0 while `mem_stall`=1.
- Upstream holds the EX/MEM inputs constant while `mem_stall`=1.
- Reset in any state:
  - Next cycle: state IDLE, `dmem_req`=0, counter 0.
  - `mem_error`=0 and all `wb_*` outputs 0.

## Timing
- Non-memory instruction: 1 cycle in the stage; visible on `wb_*` one edge after it is presented.
- Memory instruction: cycle 0 IDLE (stall); cycle 1 onward REQ with `dmem_req`=1; ack cycle N; cycle N+1 DONE (no stall); `wb_*` valid after the DONE edge.
- Zero-wait memory (ack in first REQ cycle): 3 cycles in the stage, 2 of them stalled.
- `dmem_addr`, `dmem_wdata` and `dmem_we` are stable throughout REQ.
- Reset values: `dmem_req`=0, `mem_error`=0, all `wb_*`=0. The combinational outputs follow the inputs.

## Structure
- Shared package `legv8_pkg`:
  - `mem_state_t` enum (IDLE, REQ, DONE).
  - `XLEN`=64, `REG_ADDR_W`=5.
  - WB control bundle typedef (`regwrite`, `memtoreg`).
- Sub-module `mem_wb`: MEM/WB pipeline register with a bubble-insert input and synchronous reset.
- Timeout counter width: `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- ADD result 0x2A, Write_reg=5, RegWrite=1, no mem op -> `mem_stall` never asserts; after 1 edge `wb_alu_result`=0x2A, `wb_write_reg`=5, `wb_regwrite`=1.
- LDUR addr 0x100, memory acks 3 cycles after `dmem_req` with 0xDEADBEEF -> `mem_stall` high 4 cycles; `wb_read_data`=0xDEADBEEF, `wb_memtoreg`=1; bubbles (`wb_regwrite`=0) during the stall.
- STUR addr 0x80 data 0x55 -> `dmem_we`=1, `dmem_wdata`=0x55 held through REQ; `wb_regwrite`=0 at retire.
- CBZ with Zero=1, Add_result=0x400 -> `pc_src`=1, `branch_target`=0x400; Zero=0 -> `pc_src`=0; UncBranch=1 -> `pc_src`=1.
- Load with ack never asserted, TIMEOUT_CYCLES=4 -> `dmem_req` high exactly 4 cycles, `mem_error`=1 (sticky), `wb_read_data`=0.
- Reset asserted during REQ -> next cycle `dmem_req`=0, `mem_stall`=0, all `wb_*`=0; a late ack is ignored.
